// File: rtl/instruction_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit_pkg
// Brief    : Shared types and default constants for the instruction fetch unit
// Revision : 1.0 - initial release
// ============================================================================
package instruction_fetch_unit_pkg;

  localparam int unsigned C_ADDR_W     = 8;
  localparam int unsigned C_INSTR_W    = 8;
  localparam int unsigned C_PC_STEP    = 2;
  localparam int unsigned C_FIFO_DEPTH = 2;
  localparam logic [7:0]  C_RESET_PC   = 8'h00;
  localparam logic [7:0]  C_HALT_OP    = 8'hFF;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // One prefetch entry as seen by decode
  typedef struct packed {
    logic [C_INSTR_W-1:0] instr;
    logic [C_ADDR_W-1:0]  pc;
  } entry_t;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit_if
// Brief    : Memory, branch and decode-handshake signals of the fetch unit
// Revision : 1.0 - initial release
// ============================================================================
interface instruction_fetch_unit_if
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W  = C_ADDR_W,
  parameter int unsigned INSTR_W = C_INSTR_W
);

  logic               fetch_en;
  logic [ADDR_W-1:0]  pc_address;
  logic [INSTR_W-1:0] in_instruction;
  logic               branch_valid;
  logic [ADDR_W-1:0]  branch_target;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  instr_pc;
  logic               halted;

  // Fetch unit side
  modport master (
    input  fetch_en, in_instruction, branch_valid, branch_target, instr_ready,
    output pc_address, instr_valid, instr_out, instr_pc, halted
  );

  // Environment side (memory, execute, decode)
  modport slave (
    output fetch_en, in_instruction, branch_valid, branch_target, instr_ready,
    input  pc_address, instr_valid, instr_out, instr_pc, halted
  );

endinterface
`default_nettype wire

// File: rtl/instruction_fetch_unit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit_fifo
// Brief    : Synchronous prefetch FIFO with flush; push accepted when full if
//            a pop happens in the same cycle
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             i_push,
  input  wire logic             i_pop,
  input  wire logic             i_flush,
  input  wire logic [WIDTH-1:0] i_data,
  output logic      [WIDTH-1:0] o_data,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];

  // Pointer and occupancy tracking; flush empties without touching storage
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage; cleared on reset so the head reads zero until the first push
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_unit
// Brief    : Program counter, fetch FSM and prefetch queue feeding decode;
//            supports branch redirect and halt-on-opcode
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W     = C_ADDR_W,
  parameter int unsigned       INSTR_W    = C_INSTR_W,
  parameter int unsigned       PC_STEP    = C_PC_STEP,
  parameter int unsigned       FIFO_DEPTH = C_FIFO_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(C_RESET_PC),
  parameter logic [INSTR_W-1:0] HALT_OP   = INSTR_W'(C_HALT_OP)
) (
  input wire logic                 clk,
  input wire logic                 reset,
  instruction_fetch_unit_if.master bus
);

  state_t                     r_state;
  state_t                     w_state_next;
  logic [ADDR_W-1:0]          r_pc;
  logic [ADDR_W-1:0]          w_branch_pc;
  logic                       w_branch;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_flush;
  logic                       w_halted;
  logic                       w_full;
  logic                       w_empty;
  logic [INSTR_W+ADDR_W-1:0]  w_wr_data;
  logic [INSTR_W+ADDR_W-1:0]  w_rd_data;

  // Branches land on even addresses; IDLE ignores redirects
  assign w_branch_pc = bus.branch_target & ~ADDR_W'(1);
  assign w_branch    = bus.branch_valid && (r_state != ST_IDLE);
  assign w_pop       = !w_empty && bus.instr_ready;
  assign w_wr_data   = {bus.in_instruction, r_pc};

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.fetch_en) w_state_next = ST_FETCH;
      ST_FETCH: begin
        if (w_branch)
          w_state_next = ST_FETCH;
        else if (w_push && (bus.in_instruction == HALT_OP))
          w_state_next = ST_HALT;
      end
      ST_HALT:  if (w_branch) w_state_next = ST_FETCH;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Output decode: push while fetching unless redirected or blocked by a full queue
  always_comb begin
    w_push   = 1'b0;
    w_flush  = w_branch;
    w_halted = (r_state == ST_HALT);
    if ((r_state == ST_FETCH) && !w_branch && (!w_full || w_pop))
      w_push = 1'b1;
  end

  // Program counter: redirect beats sequential advance; holds on stall
  always_ff @(posedge clk) begin
    if (reset)         r_pc <= RESET_PC;
    else if (w_branch) r_pc <= w_branch_pc;
    else if (w_push)   r_pc <= r_pc + ADDR_W'(PC_STEP);
  end

  instruction_fetch_unit_fifo #(
    .WIDTH (INSTR_W + ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (w_wr_data),
    .o_data  (w_rd_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign bus.pc_address  = r_pc;
  assign bus.instr_valid = !w_empty;
  assign bus.instr_out   = w_rd_data[INSTR_W+ADDR_W-1:ADDR_W];
  assign bus.instr_pc    = w_rd_data[ADDR_W-1:0];
  assign bus.halted      = w_halted;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Brief    : Scoreboard bench for instruction_fetch_unit; memory returns
//            addr ^ 8'hA5, with the halt opcode stored at 8'h0C
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  entry_t exp_q[$];

  instruction_fetch_unit_if #(.ADDR_W(8), .INSTR_W(8)) bus ();

  instruction_fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory model
  assign bus.in_instruction = (bus.pc_address == 8'h0C) ? 8'hFF : (bus.pc_address ^ 8'hA5);

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic expect_entry(input logic [7:0] instr, input logic [7:0] pc);
    entry_t e;
    e.instr = instr;
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every accepted head against the scoreboard
  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.instr_valid && bus.instr_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_xfer: got pc=%h instr=%h expected none", bus.instr_pc, bus.instr_out);
        end else begin
          e = exp_q.pop_front();
          if (bus.instr_pc !== e.pc || bus.instr_out !== e.instr) begin
            bad++;
            $display("FAIL xfer: got pc=%h instr=%h expected pc=%h instr=%h",
                     bus.instr_pc, bus.instr_out, e.pc, e.instr);
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [7:0] pcs  [7];
    logic [7:0] data [7];
    pcs  = '{8'h00, 8'h02, 8'h04, 8'h06, 8'h08, 8'h0A, 8'h0C};
    data = '{8'hA5, 8'hA7, 8'hA1, 8'hA3, 8'hAD, 8'hAF, 8'hFF};

    reset = 1'b1;
    bus.fetch_en      = 1'b0;
    bus.instr_ready   = 1'b0;
    bus.branch_valid  = 1'b0;
    bus.branch_target = 8'h00;
    tick(3);
    check("rst_valid",  32'(bus.instr_valid), 32'h0);
    check("rst_out",    32'(bus.instr_out),   32'h0);
    check("rst_pc",     32'(bus.instr_pc),    32'h0);
    check("rst_halted", 32'(bus.halted),      32'h0);
    check("rst_addr",   32'(bus.pc_address),  32'h0);

    // Stall with decode not ready: two entries held, PC frozen
    reset = 1'b0;
    bus.fetch_en = 1'b1;
    tick(6);
    check("stall_addr",  32'(bus.pc_address),  32'h04);
    check("stall_valid", 32'(bus.instr_valid), 32'h1);
    check("stall_pc",    32'(bus.instr_pc),    32'h00);
    check("stall_out",   32'(bus.instr_out),   32'hA5);

    // Release and stream through to the halt opcode
    for (int i = 0; i < 7; i++) expect_entry(data[i], pcs[i]);
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(1);
    check("drain1", 32'(exp_q.size()), 32'h0);
    tick(2);
    check("halt_flag",  32'(bus.halted),      32'h1);
    check("halt_addr",  32'(bus.pc_address),  32'h0E);
    check("halt_valid", 32'(bus.instr_valid), 32'h0);

    // Resume from halt via branch, then redirect to an odd target
    bus.instr_ready   = 1'b0;
    bus.branch_valid  = 1'b1;
    bus.branch_target = 8'h40;
    tick(1);
    bus.branch_valid = 1'b0;
    tick(4);
    check("resume_halted", 32'(bus.halted),     32'h0);
    check("resume_addr",   32'(bus.pc_address), 32'h44);
    check("resume_pc",     32'(bus.instr_pc),   32'h40);
    check("resume_out",    32'(bus.instr_out),  32'hE5);

    bus.branch_valid  = 1'b1;
    bus.branch_target = 8'h31;
    tick(1);
    bus.branch_valid = 1'b0;
    tick(4);
    check("odd_addr", 32'(bus.pc_address), 32'h34);
    check("odd_pc",   32'(bus.instr_pc),   32'h30);
    check("odd_out",  32'(bus.instr_out),  32'h95);
    expect_entry(8'h95, 8'h30);
    expect_entry(8'h97, 8'h32);
    expect_entry(8'h91, 8'h34);
    bus.instr_ready = 1'b1;
    tick(3);
    bus.instr_ready = 1'b0;
    check("drain2",      32'(exp_q.size()),   32'h0);
    check("stream_addr", 32'(bus.pc_address), 32'h3A);

    // Branch in the same cycle decode accepts the head: head consumed, queue flushed
    expect_entry(8'h93, 8'h36);
    bus.branch_valid  = 1'b1;
    bus.branch_target = 8'hFC;
    bus.instr_ready   = 1'b1;
    tick(1);
    bus.branch_valid = 1'b0;
    bus.instr_ready  = 1'b0;
    tick(4);
    check("wrap_addr", 32'(bus.pc_address), 32'h00);
    check("wrap_pc",   32'(bus.instr_pc),   32'hFC);
    expect_entry(8'h59, 8'hFC);
    expect_entry(8'h5B, 8'hFE);
    expect_entry(8'hA5, 8'h00);
    expect_entry(8'hA7, 8'h02);
    bus.instr_ready = 1'b1;
    tick(4);
    bus.instr_ready = 1'b0;
    check("drain3",    32'(exp_q.size()),   32'h0);
    check("post_addr", 32'(bus.pc_address), 32'h08);
    check("post_pc",   32'(bus.instr_pc),   32'h04);

    // Reset with a full queue, then confirm IDLE ignores branches
    bus.fetch_en = 1'b0;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("mid_rst_valid", 32'(bus.instr_valid), 32'h0);
    check("mid_rst_addr",  32'(bus.pc_address),  32'h00);
    check("mid_rst_out",   32'(bus.instr_out),   32'h0);
    check("mid_rst_pc",    32'(bus.instr_pc),    32'h0);
    bus.branch_valid  = 1'b1;
    bus.branch_target = 8'h80;
    tick(1);
    bus.branch_valid = 1'b0;
    tick(2);
    check("idle_br_addr",  32'(bus.pc_address),  32'h00);
    check("idle_br_valid", 32'(bus.instr_valid), 32'h0);
    bus.fetch_en = 1'b1;
    tick(4);
    check("restart_valid", 32'(bus.instr_valid), 32'h1);
    check("restart_pc",    32'(bus.instr_pc),    32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
